// File: rtl/seq_alu.sv
// Sequential ALU: add / multiply / AND / OR on WIDTH-bit operands, 2*WIDTH-bit result.
// Latency: add/AND/OR complete on the accepting edge; multiply completes WIDTH edges later.
// Backpressure: none queued; start is only accepted in IDLE, and starts during a multiply are dropped.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   X, Y, sel, start  operands, opcode (00 add, 01 mul, 10 and, 11 or) and request;
//                     X/Y/sel are sampled only on an accepted start
//   busy              high while a multiply is iterating
//   done              one-cycle pulse; Z/carry/zero are valid from the edge that raises it
//   Z, carry, zero    last completed result, add carry-out, and result-is-zero flag
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  input  logic [1:0]         sel,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Z,
  output logic               carry,
  output logic               zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int ZW = 2 * WIDTH;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Architectural state
  state_t          state_q;
  logic            busy_q;
  logic            done_q;
  logic [ZW-1:0]   z_q;
  logic            carry_q;
  logic            zero_q;

  // Multiplier datapath state
  logic [ZW-1:0]   mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [ZW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;

  // Next-state / combinational helpers
  logic [WIDTH:0]  sum_d;
  logic [ZW-1:0]   single_res_d;
  logic            single_carry_d;
  logic [ZW-1:0]   acc_d;
  logic            last_iter_d;
  logic            accept_d;

  // A start only counts while idle; nothing is buffered during a multiply.
  assign accept_d = start && (state_q == ST_IDLE);

  // One extra bit keeps the add carry-out.
  assign sum_d = {1'b0, X} + {1'b0, Y};

  // Single-cycle operation results (multiply handled by the iterative path).
  always_comb begin
    single_res_d   = '0;
    single_carry_d = 1'b0;
    case (sel)
      OP_ADD: begin
        single_res_d   = ZW'(sum_d);
        single_carry_d = sum_d[WIDTH];
      end
      OP_AND: single_res_d = ZW'(X & Y);
      OP_OR:  single_res_d = ZW'(X | Y);
      default: begin
        single_res_d   = '0;
        single_carry_d = 1'b0;
      end
    endcase
  end

  // Shift-add step: include this edge's partial product so the final edge
  // can publish the complete product directly.
  assign acc_d       = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_iter_d = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      z_q      <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            if (sel == OP_MUL) begin
              // Latch operands; Z/carry/zero keep the previous result until completion.
              mcand_q  <= {{WIDTH{1'b0}}, X};
              mplier_q <= Y;
              acc_q    <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= ST_MUL;
            end else begin
              z_q     <= single_res_d;
              carry_q <= single_carry_d;
              zero_q  <= (single_res_d == '0);
              done_q  <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (last_iter_d) begin
            z_q     <= acc_d;
            carry_q <= 1'b0;
            zero_q  <= (acc_d == '0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Z     = z_q;
  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised successor to the team's 2-bit four-operation ALU: add, multiply, bitwise AND, bitwise OR on WIDTH-bit operands.
- Result is 2*WIDTH bits wide.
- Clocked, with a start/busy/done handshake. Add, AND and OR complete in one edge; multiply is an iterative shift-add unit taking WIDTH cycles.
- Sits between operand registers and the display/result path, replacing the enable-edge-triggered ALU.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16.
- CW, $clog2(WIDTH)+1, width of the internal multiply iteration counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- X  input  WIDTH  operand A; sampled only on an accepted start.
- Y  input  WIDTH  operand B; sampled only on an accepted start.
- sel  input  2  operation: 00 add, 01 multiply, 10 AND, 11 OR; sampled only on an accepted start.
- start  input  1  request a new operation; level-sampled each edge.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse; Z is valid from the edge that raises done.
- Z  output  2*WIDTH  result of the last completed operation; held until the next completion.
- carry  output  1  add: bit WIDTH of the sum; 0 for all other ops.
- zero  output  1  high when the completed Z equals 0.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; busy=0, done=0, Z=0, carry=0, zero=1. Internal multiplicand, multiplier, accumulator and counter are cleared.
- FSM states: IDLE and MUL.
- Accepted start: start=1 at a rising edge while state=IDLE. Any start while in MUL is ignored; it is not queued.
- Default every edge: done <= 0, unless set below.
- IDLE, accepted start, sel=00: Z <= zero-extended X+Y (WIDTH+1 significant bits); carry <= sum[WIDTH]; done <= 1.
- IDLE, accepted start, sel=10: Z <= zero-extended X&Y; carry <= 0; done <= 1.
- IDLE, accepted start, sel=11: Z <= zero-extended X|Y; carry <= 0; done <= 1.
- For add, AND and OR, latency is 0 cycles: Z and done change on the accepting edge. Back-to-back starts give one result per cycle.
- IDLE, accepted start, sel=01:
  - latch MCAND <= {WIDTH zeros, X}, MPLIER <= Y, ACC <= 0, CNT <= 0;
  - busy <= 1; state <= MUL.
  - Z, carry and zero hold their previous values on this edge.
- MUL, each edge:
  - if MPLIER[0], ACC <= ACC + MCAND;
  - MCAND <= MCAND<<1; MPLIER <= MPLIER>>1; CNT <= CNT+1.
- MUL, on the edge where CNT==WIDTH-1:
  - Z <= final ACC (including this edge's addition); carry <= 0; done <= 1; busy <= 0; state <= IDLE.
  - Result: done rises on the WIDTH-th edge after the accepting edge.
  - A start on the following edge is accepted normally.
- zero is updated on every edge where done is set: zero <= (new Z == 0).
- Widths: the multiply product fits exactly in 2*WIDTH bits and never overflows. The add result uses the low WIDTH+1 bits of Z; the upper bits are 0.
- X, Y and sel may change freely after acceptance; the running multiply uses only the latched copies.
- Reset asserted mid-multiply: the operation is abandoned immediately and all outputs return to reset values. No done is produced after rst_n deasserts.
- sel values are all defined; there are no illegal codes.

Test Plan:
- WIDTH=4; after reset check Z=0, zero=1, busy=0. Then start with X=15, Y=15, sel=00 -> same edge: Z=30, carry=1, done=1 for 1 cycle, zero=0.
- X=15, Y=15, sel=01, start for 1 cycle -> busy=1 for 4 cycles; done and Z=225 on the 4th edge after acceptance; busy=0 on that same edge.
- X=4'b1100, Y=4'b1010: sel=10 -> Z=8; then sel=11 on the next cycle -> Z=14; carry=0 both times; done high on two consecutive edges.
- Start multiply 3*5; hold start=1 and change X, Y and sel during MUL -> Z=15 at completion, no extra done while busy; a new op is accepted on the edge after done.
- Start multiply 7*9; assert rst_n=0 asynchronously at cycle 2 -> Z=0, busy=0, zero=1 immediately; no done after release. A multiply of 0*9 -> Z=0, zero=1.
